// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared memory-bus encodings (M_X* function codes, MT_* mask
//          types) and the arbiter state/owner enumerations.
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Memory function codes
  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // Memory mask types
  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  localparam logic [2:0] MT_WU = 3'd6;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } ArbState;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ArbOwner;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between the instruction-fetch (I) and the
//          data (D) requester. One transaction outstanding at a time; the
//          response goes back to the requester that owns it. D has priority,
//          but after STARVE_LIMIT consecutive D grants with I waiting, I is
//          granted.
// Ports  : clk, reset            clock, synchronous active-high reset
//          i_req_* / i_res_*     fetch request (held until response) / strobe
//          d_req_* / d_res_*     data request (held until response) / strobe
//          mem_req_*             latched request towards memory (valid/ready)
//          mem_resp_*            memory response strobe and data
//          busy                  arbiter not idle
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_res_valid,
  output logic [DATA_W-1:0] i_res_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_data,
  input  logic              d_req_fcn,
  input  logic [2:0]        d_req_typ,
  output logic              d_res_valid,
  output logic [DATA_W-1:0] d_res_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);

  ArbState           r_state,      w_state_nxt;
  ArbOwner           r_owner,      w_owner_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_cnt_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [DATA_W-1:0] r_data,       w_data_nxt;
  logic              r_fcn,        w_fcn_nxt;
  logic [2:0]        r_typ,        w_typ_nxt;
  logic [DATA_W-1:0] r_rdata,      w_rdata_nxt;

  logic w_any_req;
  logic w_pick_i;

  // Winner select: D by default, I when it is alone or has been starved long enough.
  always_comb begin
    w_any_req = i_req_valid | d_req_valid;
    w_pick_i  = 1'b0;
    if (i_req_valid && !d_req_valid) begin
      w_pick_i = 1'b1;
    end else if (i_req_valid && d_req_valid && (r_starve_cnt == c_starve_limit)) begin
      w_pick_i = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_I;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_fcn        <= 1'b0;
      r_typ        <= '0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_fcn        <= w_fcn_nxt;
      r_typ        <= w_typ_nxt;
      r_rdata      <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_starve_cnt_nxt = r_starve_cnt;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_fcn_nxt        = r_fcn;
    w_typ_nxt        = r_typ;
    w_rdata_nxt      = r_rdata;
    mem_req_valid    = 1'b0;
    i_res_valid      = 1'b0;
    d_res_valid      = 1'b0;
    busy             = (r_state != ARB_IDLE);

    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ARB_ISSUE;
          if (w_pick_i) begin
            w_owner_nxt      = OWN_I;
            w_addr_nxt       = i_req_addr;
            w_data_nxt       = '0;
            w_fcn_nxt        = M_XRD;
            w_typ_nxt        = MT_WU;
            w_starve_cnt_nxt = '0;
          end else begin
            w_owner_nxt = OWN_D;
            w_addr_nxt  = d_req_addr;
            w_data_nxt  = d_req_data;
            w_fcn_nxt   = d_req_fcn;
            w_typ_nxt   = d_req_typ;
            // Only a D grant over a waiting I counts towards starvation.
            if (!i_req_valid) begin
              w_starve_cnt_nxt = '0;
            end else if (r_starve_cnt != c_starve_limit) begin
              w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
            end
          end
        end
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // Responses are only accepted here; strobes in any other state are stray.
        if (mem_resp_valid) begin
          w_rdata_nxt = mem_resp_data;
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        i_res_valid = (r_owner == OWN_I);
        d_res_valid = (r_owner == OWN_D);
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign mem_req_addr = r_addr;
  assign mem_req_data = r_data;
  assign mem_req_fcn  = r_fcn;
  assign mem_req_typ  = r_typ;
  assign i_res_data   = r_rdata;
  assign d_res_data   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench for mem_port_arbiter. A transaction-level
//          model picks the expected winner of each arbitration and queues the
//          expected memory request and response; monitors compare what the
//          DUT presents. A memory responder answers accepted requests and
//          injects stray response strobes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              reset;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_res_valid;
  logic [DATA_W-1:0] i_res_data;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_data;
  logic              d_req_fcn;
  logic [2:0]        d_req_typ;
  logic              d_res_valid;
  logic [DATA_W-1:0] d_res_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_fcn;
  logic [2:0]        mem_req_typ;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_res_valid   (i_res_valid),
    .i_res_data    (i_res_data),
    .d_req_valid   (d_req_valid),
    .d_req_addr    (d_req_addr),
    .d_req_data    (d_req_data),
    .d_req_fcn     (d_req_fcn),
    .d_req_typ     (d_req_typ),
    .d_res_valid   (d_res_valid),
    .d_res_data    (d_res_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_fcn   (mem_req_fcn),
    .mem_req_typ   (mem_req_typ),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fcn;
    logic [2:0]  typ;
  } req_t;

  typedef struct packed {
    logic        own_d;
    logic        chk_data;
    logic [31:0] data;
  } res_t;

  req_t        exp_mem_q[$];
  res_t        exp_res_q[$];
  logic [31:0] mem_data_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;
  int starve = 0;

  // Responder controls (written by the driver only)
  bit fast       = 1'b0;
  bit auto_resp  = 1'b1;
  bit stall_mode = 1'b0;
  bit inject     = 1'b0;
  // Responder status (written by the responder only)
  bit outstanding = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic die(input string what);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", what);
    summary();
    $fatal(1, "aborting run");
  endtask

  task automatic new_i();
    i_req_addr  = $urandom;
    i_req_valid = 1'b1;
    i_pend      = 1'b1;
  endtask

  task automatic new_d();
    d_req_addr  = $urandom;
    d_req_data  = $urandom;
    d_req_fcn   = 1'($urandom % 2);
    d_req_typ   = 3'($urandom_range(6, 1));
    d_req_valid = 1'b1;
    d_pend      = 1'b1;
  endtask

  task automatic drop_x(input logic own_d);
    if (own_d) begin
      d_req_valid = 1'b0;
      d_pend      = 1'b0;
    end else begin
      i_req_valid = 1'b0;
      i_pend      = 1'b0;
    end
  endtask

  // Arbitration rules applied to the current pending set; queues expectations.
  task automatic grant(input logic [31:0] rdata, output logic own_d);
    req_t r;
    own_d = d_pend && !(i_pend && starve == STARVE_LIMIT);
    if (own_d) begin
      if (i_pend) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else        starve = 0;
      r = '{addr: d_req_addr, data: d_req_data, fcn: d_req_fcn, typ: d_req_typ};
      d_pend = 1'b0;
    end else begin
      starve = 0;
      r = '{addr: i_req_addr, data: 32'h0, fcn: M_XRD, typ: MT_WU};
      i_pend = 1'b0;
    end
    exp_mem_q.push_back(r);
    mem_data_q.push_back(rdata);
    exp_res_q.push_back('{own_d: own_d, chk_data: (!own_d || r.fcn == M_XRD), data: rdata});
  endtask

  // Waits for the winner's response strobe; returns the negedge count since the request was sampled.
  task automatic wait_resp(input logic own_d, input bit mutate, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (own_d ? d_res_valid : i_res_valid) break;
      if (lat > 200) die("resp_timeout");
      if (mutate && lat >= 2) begin
        if ($urandom % 5 == 0) begin
          if (own_d) begin
            d_req_addr = $urandom;
            d_req_data = $urandom;
            if ($urandom % 3 == 0) d_req_valid = 1'b0;
          end else begin
            i_req_addr = $urandom;
            if ($urandom % 3 == 0) i_req_valid = 1'b0;
          end
        end
        if ($urandom % 8 == 0) begin
          if (own_d && !i_pend) new_i();
          else if (!own_d && !d_pend) new_d();
        end
      end
    end
  endtask

  // mode 0: both requesters always busy, 1: random, 2: drain
  task automatic round(input int mode);
    logic own_d;
    int   lat;
    if (!i_pend && !d_pend) begin
      if (mode == 2) return;
      repeat ($urandom % 3) @(negedge clk);
      case ((mode == 0) ? 2 : int'($urandom % 4))
        0:       new_i();
        1:       new_d();
        default: begin new_i(); new_d(); end
      endcase
    end else if (mode == 0) begin
      if (!i_pend) new_i();
      if (!d_pend) new_d();
    end
    grant($urandom, own_d);
    wait_resp(own_d, mode == 1, lat);
    if (mode == 0) begin
      if (own_d) new_d(); else new_i();
    end else if (mode == 1 && ($urandom % 4 != 0)) begin
      if (own_d) new_d(); else new_i();
    end else begin
      drop_x(own_d);
    end
  endtask

  // Memory responder
  initial begin : responder
    int          delay;
    int          held;
    logic [31:0] cur_data;
    delay = 0;
    held = 0;
    cur_data = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      if (!mem_req_valid) held = 0;
      if (stall_mode && mem_req_valid && held < 5) begin
        mem_req_ready = 1'b0;
        held++;
      end else begin
        mem_req_ready = fast ? 1'b1 : ($urandom % 3 != 0);
      end
      if (outstanding) begin
        if (inject || (auto_resp && delay == 0)) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = cur_data;
          outstanding    = 1'b0;
        end else if (delay > 0) begin
          delay--;
        end
      end else begin
        // Stray strobes while idle, issuing, or in the acceptance cycle.
        mem_resp_valid = fast ? 1'b1 : ($urandom % 4 == 0);
        if (mem_req_valid && mem_req_ready && !reset) begin
          outstanding = 1'b1;
          delay       = fast ? 0 : int'($urandom % 3);
          cur_data    = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : 32'h0BAD_0BAD;
        end
      end
    end
  end

  // Monitor: compares presented requests/responses against the queued expectations
  initial begin : monitor
    req_t held_req;
    req_t cur;
    req_t e;
    res_t er;
    bit   holding;
    holding  = 1'b0;
    held_req = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        holding = 1'b0;
      end else begin
        cur = '{addr: mem_req_addr, data: mem_req_data, fcn: mem_req_fcn, typ: mem_req_typ};
        if (mem_req_valid) begin
          check("busy_in_issue", busy, 1);
          if (holding) check("mem_req_stable", cur, held_req);
          if (mem_req_ready) begin
            holding = 1'b0;
            if (exp_mem_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mem_req_unexpected: got request addr %0h, expected none", mem_req_addr);
            end else begin
              e = exp_mem_q.pop_front();
              check("mem_req_addr", mem_req_addr, e.addr);
              check("mem_req_data", mem_req_data, e.data);
              check("mem_req_fcn", mem_req_fcn, e.fcn);
              check("mem_req_typ", mem_req_typ, e.typ);
            end
          end else begin
            holding  = 1'b1;
            held_req = cur;
          end
        end
        if (i_res_valid || d_res_valid) begin
          check("res_exclusive", i_res_valid & d_res_valid, 0);
          check("no_req_during_resp", mem_req_valid, 0);
          if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got i=%0b d=%0b strobe, expected none", i_res_valid, d_res_valid);
          end else begin
            er = exp_res_q.pop_front();
            check("res_owner_d", d_res_valid, er.own_d);
            if (er.chk_data) check("res_data", er.own_d ? d_res_data : i_res_data, er.data);
          end
        end
      end
    end
  end

  // Main driver
  initial begin : driver
    logic own_d;
    int   lat;
    int   n;
    reset       = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_addr  = '0;
    d_req_data  = '0;
    d_req_fcn   = 1'b0;
    d_req_typ   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_i_res_valid", i_res_valid, 0);
    check("rst_d_res_valid", d_res_valid, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_mem_req_data", mem_req_data, 0);
    check("rst_mem_req_fcn", mem_req_fcn, 0);
    check("rst_mem_req_typ", mem_req_typ, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 30; r++) round(0);
    for (int r = 0; r < 200; r++) round(1);
    while (i_pend || d_pend) round(2);
    @(negedge clk);

    // Fetch read with immediate ready and response, stray strobes everywhere else
    fast        = 1'b1;
    i_req_addr  = 32'h0000_0100;
    i_req_valid = 1'b1;
    i_pend      = 1'b1;
    grant(32'hDEAD_BEEF, own_d);
    wait_resp(own_d, 1'b0, lat);
    check("i_latency", lat, 3);
    drop_x(own_d);
    @(negedge clk);

    // Halfword store
    d_req_addr  = 32'h0000_0040;
    d_req_data  = 32'h0000_1234;
    d_req_fcn   = M_XWR;
    d_req_typ   = MT_H;
    d_req_valid = 1'b1;
    d_pend      = 1'b1;
    grant($urandom, own_d);
    wait_resp(own_d, 1'b0, lat);
    check("d_latency", lat, 3);
    drop_x(own_d);
    @(negedge clk);

    // Memory stalls acceptance for 5 cycles
    stall_mode = 1'b1;
    new_d();
    grant($urandom, own_d);
    wait_resp(own_d, 1'b0, lat);
    check("stall_latency", lat, 8);
    drop_x(own_d);
    stall_mode = 1'b0;
    @(negedge clk);

    // Reset while waiting for memory; the late response must be dropped
    auto_resp = 1'b0;
    new_i();
    grant($urandom, own_d);
    n = 0;
    while (!outstanding) begin
      @(negedge clk);
      n++;
      if (n > 50) die("accept_timeout");
    end
    @(negedge clk);
    check("busy_in_wait", busy, 1);
    reset = 1'b1;
    drop_x(own_d);
    @(negedge clk);
    reset  = 1'b0;
    inject = 1'b1;
    exp_res_q.delete();
    starve = 0;
    repeat (4) @(negedge clk);
    inject = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_mem_req_valid", mem_req_valid, 0);
    check("post_rst_mem_req_addr", mem_req_addr, 0);

    // Normal service after the reset
    fast      = 1'b0;
    auto_resp = 1'b1;
    new_i();
    grant($urandom, own_d);
    wait_resp(own_d, 1'b0, lat);
    drop_x(own_d);
    repeat (3) @(negedge clk);
    check("exp_res_q_empty", exp_res_q.size(), 0);
    check("exp_mem_q_empty", exp_mem_q.size(), 0);

    summary();
    $finish;
  end

endmodule
`default_nettype wire
